// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, byte-addressed memory between the CPU fetch (I)
// and load/store (D) ports: D wins, a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_IWAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [2:0]        d_fn,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [2:0]        m_fn,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        dbg_owner,
  output logic [3:0]        dbg_iwait_cnt
);

  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_SB  = 3'd3;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  localparam logic [3:0] IWAIT_LIMIT = 4'(MAX_IWAIT);

  // Read-return owner: which port receives m_rdata in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t     owner, owner_next;
  logic [3:0] i_wait_cnt, i_wait_next;
  logic       err_q, err_next;

  logic starve;
  logic grant_i;
  logic grant_d;
  logic d_misaligned;
  logic d_store;
  logic issue_d;

  // Handshake: a port holds req and its fields stable until it sees ready=1;
  // ready is combinational in the grant cycle and the request is consumed on
  // that rising edge. Read data comes back exactly one cycle after issue.

  always_comb begin
    d_misaligned = 1'b0;
    case (d_fn)
      MEM_LW, MEM_SW:          d_misaligned = (d_addr[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: d_misaligned = d_addr[0];
      default:                 d_misaligned = 1'b0;
    endcase
  end

  assign d_store = (d_fn == MEM_SB) || (d_fn == MEM_SH) || (d_fn == MEM_SW);

  always_comb begin
    starve  = (i_wait_cnt == IWAIT_LIMIT);
    grant_i = !reset && i_req && (starve || !d_req);
    grant_d = !reset && d_req && !grant_i;
    issue_d = grant_d && !d_misaligned;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_NONE;
      i_wait_cnt <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      owner      <= owner_next;
      i_wait_cnt <= i_wait_next;
      err_q      <= err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    owner_next  = OWN_NONE;
    i_wait_next = i_wait_cnt;
    err_next    = grant_d && d_misaligned;

    if (grant_i) begin
      owner_next = OWN_I;
    end else if (issue_d && !d_store) begin
      owner_next = OWN_D;
    end

    // A denied fetch ages toward a forced grant; saturating keeps it forced.
    if (!i_req || grant_i) begin
      i_wait_next = 4'd0;
    end else if (i_wait_cnt != IWAIT_LIMIT) begin
      i_wait_next = i_wait_cnt + 4'd1;
    end
  end

  // Output logic.
  always_comb begin
    i_ready  = grant_i;
    d_ready  = grant_d;

    m_en     = grant_i || issue_d;
    m_we     = issue_d && d_store;
    m_fn     = 3'd0;
    m_addr   = '0;
    m_wdata  = '0;
    if (grant_i) begin
      m_fn   = MEM_LW;
      m_addr = i_addr;
    end else if (grant_d) begin
      m_fn    = d_fn;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end

    // Returns and errors are masked during reset so a dropped read is silent.
    i_rvalid = !reset && (owner == OWN_I);
    d_rvalid = !reset && (owner == OWN_D);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
    d_err    = !reset && err_q;

    dbg_owner     = owner;
    dbg_iwait_cnt = i_wait_cnt;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-addressed memory between the fetch (I) port and the load/store (D) port of the pipelined CPU.
- Grants one access per cycle, returns read data one cycle later and raises per-port ready so the pipeline stalls when its port is not granted.
- D has priority. A starvation counter forces an I grant so fetch always makes progress.
- Sits between CPU and MEM.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_IWAIT, 3, consecutive denied I-request cycles before I is forced to win (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address (word aligned)
- i_ready  out  1  I request accepted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  load/store request
- d_fn  in  3  access type, define.vh MEM_* encodings (LB/LBU/LH/LHU/LW/SB/SH/SW)
- d_addr  in  ADDR_W  byte address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  D request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- d_err  out  1  misaligned D access rejected
- m_en  out  1  memory access this cycle
- m_we  out  1  write (store)
- m_fn  out  3  access type to memory
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  store data
- m_rdata  in  DATA_W  memory read data, valid one cycle after a read issue

Behaviour:
- Handshake:
  - A requester holds req and its fields stable until it sees ready=1.
  - ready is combinational in the grant cycle; the request is consumed on that clk edge.
- Grant rule, evaluated each cycle while reset=0:
  - starve = (i_wait_cnt == MAX_IWAIT).
  - If i_req and (starve or !d_req): grant I.
  - Else if d_req: grant D.
  - Else: no grant.
- Misalignment check on the D port:
  - Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - A granted misaligned D request gives d_ready=1 and m_en=0, and d_err=1 in the next cycle.
  - It produces no d_rvalid and no memory write.
- Memory outputs in a grant cycle (combinational):
  - m_en = 1 only for an I grant or an aligned D grant.
  - m_we = D grant and d_fn is SB/SH/SW.
  - m_fn = d_fn for D, MEM_LW for I.
  - m_addr and m_wdata come from the granted port.
  - With no grant, all m_* = 0.
- Read return:
  - Owner register, states NONE/I/D, is set at each read issue.
  - The next cycle pulses i_rvalid or d_rvalid for one cycle. i_rdata/d_rdata = m_rdata while valid, 0 otherwise.
  - Stores return no rvalid; they complete in the issue cycle.
- Pipelining: a new grant may issue in the same cycle a previous read returns, so back-to-back reads give 1 access/cycle.
- Starvation counter i_wait_cnt (4 bit):
  - Increments when i_req=1 and I is not granted.
  - Clears on an I grant or when i_req=0.
  - Saturates at MAX_IWAIT.
- Reset, at the synchronous edge with reset=1:
  - owner=NONE, i_wait_cnt=0, i_rvalid=d_rvalid=d_err=0.
  - While reset=1: no grants; ready and m_* outputs are 0.
  - A read outstanding at reset is dropped; no rvalid follows reset.
- Widths: no arithmetic on data. Sub-word extension is done by the memory per m_fn.

Test Plan:
- I only, i_req=1 with addr 0x0, 0x4, 0x8 on consecutive cycles:
  - i_ready=1 every cycle, m_fn=LW.
  - i_rvalid=1 one cycle after each issue, i_rdata=mem word.
  - Sustained 1 access/cycle.
- Simultaneous i_req and d_req with d_fn=SW, addr 0x100, wdata 0xDEADBEEF:
  - D granted, m_we=1, i_ready=0, i_wait_cnt=1.
  - I granted the next cycle.
  - A later LW of 0x100 returns 0xDEADBEEF.
- d_req held high with loads, i_req high, MAX_IWAIT=3:
  - D granted 3 cycles, then I forced on the 4th.
  - Counter returns to 0 and D resumes.
- LW at 0x102 and SH at 0x101:
  - d_ready=1, m_en=0, d_err=1 next cycle.
  - No rvalid, memory unchanged.
- Store then load sequence SB 0x80 data 0x000000F0, then LB 0x80 → d_rdata=0xFFFFFFF0; then LBU 0x80 → d_rdata=0x000000F0.
- Reset asserted the cycle after an I read issue:
  - No i_rvalid afterwards; all outputs 0 while reset=1.
  - First grant occurs the first cycle after reset deasserts.
